// File: rtl/cdb_pkg.sv
// Shared CDB types and defaults; also imported by the ROB, the reservation stations and the register status table.
package cdb_pkg;
  localparam int CDB_NUM_REQ = 5;
  localparam int CDB_DATA_W  = 32;
  localparam int CDB_TAG_W   = 4;

  typedef struct packed {
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] value;
    logic                  br_taken;
  } cdb_packet_t;

  // ROB tag 0 never names a live entry.
  localparam logic [CDB_TAG_W-1:0] CDB_TAG_INVALID = '0;

  function automatic logic tag_is_valid(input logic [CDB_TAG_W-1:0] t);
    return t != CDB_TAG_INVALID;
  endfunction
endpackage

// File: rtl/rr_picker.sv
// Combinational rotating-priority encoder: first eligible index at or after ptr, wrapping modulo N.
// Written generically so RS-to-ALU dispatch can reuse it.
module rr_picker #(
  parameter int N     = 5,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     eligible,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic             any_grant,
  output logic [IDX_W-1:0] winner
);
  always_comb begin
    int idx;
    grant     = '0;
    any_grant = 1'b0;
    winner    = '0;
    idx       = 0;
    for (int off = 0; off < N; off++) begin
      // N need not be a power of two, so wrap explicitly.
      idx = int'(ptr) + off;
      if (idx >= N) idx = idx - N;
      if (!any_grant && eligible[IDX_W'(idx)]) begin
        grant[IDX_W'(idx)] = 1'b1;
        any_grant          = 1'b1;
        winner             = IDX_W'(idx);
      end
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: rotating-priority grant among result producers, registered broadcast.
// Optional CDB_LSQ_PRIORITY_EN: the LSQ load port (index NUM_REQ-1) preempts the round-robin ring.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_REQ = CDB_NUM_REQ,
  parameter int DATA_W  = CDB_DATA_W,
  parameter int TAG_W   = CDB_TAG_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic        [NUM_REQ-1:0]  req_valid,
  input  cdb_packet_t [NUM_REQ-1:0]  req_pkt,
  output logic        [NUM_REQ-1:0]  req_ready,
  output logic                       cdb_valid,
  output logic        [TAG_W-1:0]    cdb_tag,
  output logic        [DATA_W-1:0]   cdb_value,
  output logic                       cdb_br_taken
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] elig, drop, pick_elig, pick_oh, win_oh;
  logic               pick_any, win_any, adv_ptr, grant_ok;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt, pick_idx, win_idx;
  cdb_packet_t        win_pkt;

  // Valid requests carrying the invalid tag are acknowledged and discarded.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign elig[i] = req_valid[i] &  tag_is_valid(req_pkt[i].tag);
    assign drop[i] = req_valid[i] & ~tag_is_valid(req_pkt[i].tag);
  end

`ifdef CDB_LSQ_PRIORITY_EN
  logic lsq_win;
  assign lsq_win   = elig[NUM_REQ-1];
  assign pick_elig = {1'b0, elig[NUM_REQ-2:0]};
  assign win_any   = lsq_win | pick_any;
  assign win_idx   = lsq_win ? IDX_W'(NUM_REQ-1) : pick_idx;
  assign win_oh    = lsq_win ? {1'b1, {(NUM_REQ-1){1'b0}}} : pick_oh;
  // An LSQ preemption leaves the ring position untouched.
  assign adv_ptr   = pick_any & ~lsq_win;
`else
  assign pick_elig = elig;
  assign win_any   = pick_any;
  assign win_idx   = pick_idx;
  assign win_oh    = pick_oh;
  assign adv_ptr   = pick_any;
`endif

  rr_picker #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .eligible  (pick_elig),
    .ptr       (rr_ptr),
    .grant     (pick_oh),
    .any_grant (pick_any),
    .winner    (pick_idx)
  );

  assign grant_ok   = win_any & ~flush & ~reset;
  assign win_pkt    = req_pkt[win_idx];
  assign rr_ptr_nxt = (win_idx == IDX_W'(NUM_REQ-1)) ? '0 : win_idx + IDX_W'(1);
  assign req_ready  = (grant_ok ? win_oh : '0) | (reset ? '0 : drop);

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr       <= '0;
      cdb_valid    <= 1'b0;
      cdb_tag      <= '0;
      cdb_value    <= '0;
      cdb_br_taken <= 1'b0;
    end else begin
      cdb_valid <= grant_ok;
      // Payload only moves on a grant; consumers key off cdb_valid.
      if (grant_ok) begin
        cdb_tag      <= win_pkt.tag;
        cdb_value    <= win_pkt.value;
        cdb_br_taken <= win_pkt.br_taken;
        if (adv_ptr) rr_ptr <= rr_ptr_nxt;
      end
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: queue-free behavioural model checked every cycle plus directed literal checks.
module tb_cdb_arbiter;
  import cdb_pkg::*;
  localparam int N = CDB_NUM_REQ;

  logic                 clk = 1'b0;
  logic                 reset, flush;
  logic        [N-1:0]  req_valid;
  cdb_packet_t [N-1:0]  req_pkt;
  logic        [N-1:0]  req_ready;
  logic                 cdb_valid, cdb_br_taken;
  logic [CDB_TAG_W-1:0] cdb_tag;
  logic [CDB_DATA_W-1:0] cdb_value;

  int checks = 0, errors = 0;
  logic chk_en = 1'b0;

  cdb_arbiter dut (
    .clk(clk), .reset(reset), .flush(flush), .req_valid(req_valid), .req_pkt(req_pkt),
    .req_ready(req_ready), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_value(cdb_value), .cdb_br_taken(cdb_br_taken)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model state: where the ring search starts, and what the bus should show.
  int          m_ptr = 0;
  logic        m_valid = 1'b0, m_br = 1'b0;
  logic [CDB_TAG_W-1:0]  m_tag = '0;
  logic [CDB_DATA_W-1:0] m_value = '0;

  function automatic bit is_elig(int i);
    return req_valid[i] && req_pkt[i].tag != 0;
  endfunction

  // Winner index for the current inputs, -1 if none.
  function automatic int pick();
`ifdef CDB_LSQ_PRIORITY_EN
    if (is_elig(N-1)) return N-1;
    for (int k = 0; k < N; k++) begin
      int i = (m_ptr + k) % N;
      if (i != N-1 && is_elig(i)) return i;
    end
`else
    for (int k = 0; k < N; k++) begin
      int i = (m_ptr + k) % N;
      if (is_elig(i)) return i;
    end
`endif
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r = '0;
    int w;
    if (!reset) begin
      for (int i = 0; i < N; i++) if (req_valid[i] && req_pkt[i].tag == 0) r[i] = 1'b1;
      w = pick();
      if (w >= 0 && !flush) r[w] = 1'b1;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    int w;
    if (reset) begin
      m_ptr <= 0; m_valid <= 1'b0; m_tag <= '0; m_value <= '0; m_br <= 1'b0;
    end else begin
      w = pick();
      if (w >= 0 && !flush) begin
        m_valid <= 1'b1;
        m_tag   <= req_pkt[w].tag;
        m_value <= req_pkt[w].value;
        m_br    <= req_pkt[w].br_taken;
`ifdef CDB_LSQ_PRIORITY_EN
        if (w != N-1) m_ptr <= (w + 1) % N;
`else
        m_ptr <= (w + 1) % N;
`endif
      end else begin
        m_valid <= 1'b0;
      end
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("model_ready", 64'(req_ready), 64'(exp_ready()));
    chk("model_cdb_valid", 64'(cdb_valid), 64'(m_valid));
    chk("model_cdb_tag", 64'(cdb_tag), 64'(m_tag));
    chk("model_cdb_value", 64'(cdb_value), 64'(m_value));
    chk("model_cdb_br", 64'(cdb_br_taken), 64'(m_br));
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int i, input logic [CDB_TAG_W-1:0] t,
                         input logic [CDB_DATA_W-1:0] v, input logic b);
    req_pkt[i].tag = t; req_pkt[i].value = v; req_pkt[i].br_taken = b;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = '0; tick(); reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; req_valid = '0; req_pkt = '0;
    tick();
    chk_en = 1'b1;
    // Invalid-tag drop is not acknowledged while in reset.
    set_req(2, 0, 32'h1, 1'b0); req_valid = 5'b00100;
    @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_cdb_valid", 64'(cdb_valid), 64'h0);
    chk("rst_cdb_tag", 64'(cdb_tag), 64'h0);
    tick(); reset = 1'b0; req_valid = '0;

    // Single request.
    set_req(0, 3, 32'hDEAD_BEEF, 1'b0); req_valid = 5'b00001;
    @(negedge clk); chk("single_ready", 64'(req_ready), 64'h01);
    tick(); req_valid = '0;
    @(negedge clk);
    chk("single_valid", 64'(cdb_valid), 64'h1);
    chk("single_tag", 64'(cdb_tag), 64'h3);
    chk("single_value", 64'(cdb_value), 64'hDEAD_BEEF);
    // Pointer now 1: with 0 and 1 pending, 1 wins first.
    tick();
    set_req(0, 6, 32'h60, 1'b0); set_req(1, 8, 32'h80, 1'b1); req_valid = 5'b00011;
    @(negedge clk); chk("ptr1_ready", 64'(req_ready), 64'h02);
    tick(); req_valid = 5'b00001;
    @(negedge clk);
    chk("ptr1_next_ready", 64'(req_ready), 64'h01);
    chk("ptr1_tag", 64'(cdb_tag), 64'h8);
    tick(); req_valid = '0;

    // Fairness from reset: tags 1..5 in order, then wrap.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, CDB_TAG_W'(i + 1), 32'(100 + i), i[0]);
    req_valid = 5'b11111;
    for (int k = 1; k <= 6; k++) begin
      tick(); @(negedge clk);
      chk("fair_tag", 64'(cdb_tag), 64'(((k - 1) % 5) + 1));
    end
    tick(); req_valid = '0;

    // Invalid tag alongside a real one.
    set_req(2, 0, 32'hBAD, 1'b0); set_req(3, 7, 32'h1234_5678, 1'b1); req_valid = 5'b01100;
    @(negedge clk); chk("inv_ready", 64'(req_ready), 64'h0C);
    tick(); req_valid = '0;
    @(negedge clk);
    chk("inv_valid", 64'(cdb_valid), 64'h1);
    chk("inv_tag", 64'(cdb_tag), 64'h7);
    chk("inv_br", 64'(cdb_br_taken), 64'h1);
    tick(); @(negedge clk);
    chk("idle_valid", 64'(cdb_valid), 64'h0);
    chk("idle_tag_hold", 64'(cdb_tag), 64'h7);
    tick();

    // Flush blocks the grant; the held request goes next cycle.
    set_req(1, 9, 32'hF00D, 1'b0); req_valid = 5'b00010; flush = 1'b1;
    @(negedge clk); chk("flush_ready", 64'(req_ready), 64'h0);
    tick(); flush = 1'b0;
    @(negedge clk);
    chk("flush_cdb_valid", 64'(cdb_valid), 64'h0);
    chk("flush_regrant", 64'(req_ready), 64'h02);
    tick(); req_valid = '0;
    @(negedge clk);
    chk("flush_bcast_valid", 64'(cdb_valid), 64'h1);
    chk("flush_bcast_tag", 64'(cdb_tag), 64'h9);
    tick();

    // Reset plus flush mid-stream.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, CDB_TAG_W'(i + 1), 32'(200 + i), 1'b0);
    req_valid = 5'b11111;
    tick(); tick(); tick();
    reset = 1'b1; flush = 1'b1;
    @(negedge clk); chk("mid_rst_ready", 64'(req_ready), 64'h0);
    tick(); reset = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("mid_cdb_valid", 64'(cdb_valid), 64'h0);
    chk("mid_ready", 64'(req_ready), 64'h01);
    tick(); req_valid = '0;

    // LSQ vs ring slot with pointer at 1.
    do_reset();
    set_req(0, 2, 32'h22, 1'b0); req_valid = 5'b00001;
    tick();
    set_req(1, 11, 32'hB1, 1'b0); set_req(4, 12, 32'hC4, 1'b1); req_valid = 5'b10010;
`ifdef CDB_LSQ_PRIORITY_EN
    @(negedge clk); chk("lsq_first", 64'(req_ready), 64'h10);
    tick(); req_valid = 5'b00010;
    @(negedge clk);
    chk("lsq_second", 64'(req_ready), 64'h02);
    chk("lsq_tag", 64'(cdb_tag), 64'hC);
`else
    @(negedge clk); chk("ring_first", 64'(req_ready), 64'h02);
    tick(); req_valid = 5'b10000;
    @(negedge clk);
    chk("ring_second", 64'(req_ready), 64'h10);
    chk("ring_tag", 64'(cdb_tag), 64'hB);
`endif
    tick(); req_valid = '0;
    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
